// File: rtl/rtype_issue_unit.sv
// Single-issue decode/rename stage for RV32I OP and OP-IMM instructions.
// Renames through an internal RAT, allocates the ROB tail and writes one ALU RS entry.
module rtype_issue_unit #(
  parameter  int XLEN      = 32,
  parameter  int NUM_RS    = 2,
  parameter  int ROB_DEPTH = 8,
  localparam int TAG_W     = $clog2(ROB_DEPTH),
  localparam int IDX_W     = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [31:0]         in_pc,
  input  logic [NUM_RS-1:0]   rs_busy,
  input  logic                rob_full,
  input  logic [TAG_W-1:0]    rob_head,
  output logic [4:0]          rf_raddr1,
  output logic [4:0]          rf_raddr2,
  input  logic [XLEN-1:0]     rf_rdata1,
  input  logic [XLEN-1:0]     rf_rdata2,
  output logic [TAG_W-1:0]    rob_q1_tag,
  output logic [TAG_W-1:0]    rob_q2_tag,
  input  logic                rob_q1_done,
  input  logic [XLEN-1:0]     rob_q1_value,
  input  logic                rob_q2_done,
  input  logic [XLEN-1:0]     rob_q2_value,
  input  logic                cdb_valid,
  input  logic [TAG_W-1:0]    cdb_tag,
  input  logic [XLEN-1:0]     cdb_value,
  input  logic                commit_valid,
  input  logic [4:0]          commit_rd,
  input  logic [TAG_W-1:0]    commit_tag,
  input  logic                flush,
  output logic                rs_we,
  output logic [IDX_W-1:0]    rs_idx,
  output logic [5:0]          rs_funct,
  output logic [TAG_W-1:0]    rs_dest_tag,
  output logic                rs_src1_ready,
  output logic [TAG_W-1:0]    rs_src1_tag,
  output logic [XLEN-1:0]     rs_src1_value,
  output logic                rs_src2_ready,
  output logic [TAG_W-1:0]    rs_src2_tag,
  output logic [XLEN-1:0]     rs_src2_value,
  output logic                rob_alloc,
  output logic [TAG_W-1:0]    rob_alloc_tag,
  output logic [4:0]          rob_alloc_rd,
  output logic [31:0]         rob_alloc_pc,
  output logic                illegal_instr
);

  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } opnd_t;

  logic             dec_valid_q, dec_valid_d;
  logic [31:0]      dec_instr_q, dec_instr_d;
  logic [31:0]      dec_pc_q, dec_pc_d;
  logic [TAG_W-1:0] rob_tail_q, rob_tail_d;
  logic [31:0]      rat_valid_q, rat_valid_d;
  logic [TAG_W-1:0] rat_tag_q [32];
  logic [TAG_W-1:0] rat_tag_d [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        b30, is_op, is_imm, legal;
  logic [11:0] imm;
  logic [5:0]  funct;
  logic        rs_free, issue_fire, accept;
  logic [IDX_W-1:0] rs_slot;
  opnd_t       src1, src2;

  assign opcode = dec_instr_q[6:0];
  assign rd     = dec_instr_q[11:7];
  assign f3     = dec_instr_q[14:12];
  assign rs1    = dec_instr_q[19:15];
  assign rs2    = dec_instr_q[24:20];
  assign imm    = dec_instr_q[31:20];
  assign b30    = dec_instr_q[30];
  assign is_op  = (opcode == 7'b0110011);
  assign is_imm = (opcode == 7'b0010011);
  // OP only allows bit30 on SUB and SRA; OP-IMM ignores it (imm bits or SRAI).
  assign legal  = is_imm || (is_op && (!b30 || f3 == 3'b000 || f3 == 3'b101));

  always_comb begin
    rs_slot = '0;
    rs_free = 1'b0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (!rs_busy[i]) begin
        rs_slot = IDX_W'(i);
        rs_free = 1'b1;
      end
    end
  end

  assign issue_fire    = dec_valid_q && legal && !rob_full && rs_free && !flush;
  assign in_ready      = !flush && (!dec_valid_q || issue_fire);
  assign accept        = in_valid && in_ready;
  assign illegal_instr = dec_valid_q && !legal && !flush;

  always_comb begin
    funct = 6'b011011;
    case (f3)
      3'b000:  funct = (is_op && b30) ? 6'b011100 : 6'b011011;
      3'b001:  funct = 6'b011101;
      3'b010:  funct = 6'b011110;
      3'b011:  funct = 6'b011111;
      3'b100:  funct = 6'b100000;
      3'b101:  funct = b30 ? 6'b100010 : 6'b100001;
      3'b110:  funct = 6'b100011;
      default: funct = 6'b100100;
    endcase
  end

  function automatic opnd_t resolve(
    input logic [4:0]       rs,
    input logic             rat_v,
    input logic [TAG_W-1:0] rat_t,
    input logic [XLEN-1:0]  rf_v,
    input logic             q_done,
    input logic [XLEN-1:0]  q_val,
    input logic             c_valid,
    input logic [TAG_W-1:0] c_tag,
    input logic [XLEN-1:0]  c_val
  );
    opnd_t o;
    o = '{rdy: 1'b1, tag: '0, val: '0};
    if (rs == 5'd0)                    o.val = '0;
    else if (rat_v)                    o.val = rf_v;
    else if (c_valid && c_tag == rat_t) o.val = c_val;
    else if (q_done)                   o.val = q_val;
    else begin
      o.rdy = 1'b0;
      o.tag = rat_t;
    end
    return o;
  endfunction

  assign rf_raddr1  = rs1;
  assign rf_raddr2  = rs2;
  assign rob_q1_tag = rat_tag_q[rs1];
  assign rob_q2_tag = rat_tag_q[rs2];

  always_comb begin
    src1 = resolve(rs1, rat_valid_q[rs1], rat_tag_q[rs1], rf_rdata1, rob_q1_done,
                   rob_q1_value, cdb_valid, cdb_tag, cdb_value);
    src2 = resolve(rs2, rat_valid_q[rs2], rat_tag_q[rs2], rf_rdata2, rob_q2_done,
                   rob_q2_value, cdb_valid, cdb_tag, cdb_value);
    if (is_imm) begin
      src2.rdy = 1'b1;
      src2.tag = '0;
      src2.val = (f3 == 3'b001 || f3 == 3'b101) ? {{(XLEN-5){1'b0}}, imm[4:0]}
                                                : {{(XLEN-12){imm[11]}}, imm};
    end
  end

  // Stage I: payload is driven only while the write strobes are high.
  always_comb begin
    rs_we         = issue_fire;
    rob_alloc     = issue_fire;
    rs_idx        = '0;
    rs_funct      = '0;
    rs_dest_tag   = '0;
    rs_src1_ready = 1'b0;
    rs_src1_tag   = '0;
    rs_src1_value = '0;
    rs_src2_ready = 1'b0;
    rs_src2_tag   = '0;
    rs_src2_value = '0;
    rob_alloc_tag = '0;
    rob_alloc_rd  = '0;
    rob_alloc_pc  = '0;
    if (issue_fire) begin
      rs_idx        = rs_slot;
      rs_funct      = funct;
      rs_dest_tag   = rob_tail_q;
      rs_src1_ready = src1.rdy;
      rs_src1_tag   = src1.tag;
      rs_src1_value = src1.val;
      rs_src2_ready = src2.rdy;
      rs_src2_tag   = src2.tag;
      rs_src2_value = src2.val;
      rob_alloc_tag = rob_tail_q;
      rob_alloc_rd  = rd;
      rob_alloc_pc  = dec_pc_q;
    end
  end

  always_comb begin
    dec_valid_d = dec_valid_q;
    dec_instr_d = dec_instr_q;
    dec_pc_d    = dec_pc_q;
    rob_tail_d  = rob_tail_q;
    rat_valid_d = rat_valid_q;
    rat_tag_d   = rat_tag_q;
    if (flush) begin
      dec_valid_d = 1'b0;
      rat_valid_d = '1;
      rob_tail_d  = rob_head;
    end else begin
      if (accept) begin
        dec_valid_d = 1'b1;
        dec_instr_d = in_instr;
        dec_pc_d    = in_pc;
      end else if (issue_fire || illegal_instr) begin
        dec_valid_d = 1'b0;
      end
      if (commit_valid && !rat_valid_q[commit_rd] && rat_tag_q[commit_rd] == commit_tag)
        rat_valid_d[commit_rd] = 1'b1;
      // Rename after commit so a same-cycle issue to the same rd wins.
      if (issue_fire) begin
        rob_tail_d = rob_tail_q + 1'b1;
        if (rd != 5'd0) begin
          rat_valid_d[rd] = 1'b0;
          rat_tag_d[rd]   = rob_tail_q;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dec_valid_q <= 1'b0;
      dec_instr_q <= '0;
      dec_pc_q    <= '0;
      rob_tail_q  <= '0;
      rat_valid_q <= '1;
      for (int i = 0; i < 32; i++) rat_tag_q[i] <= '0;
    end else begin
      dec_valid_q <= dec_valid_d;
      dec_instr_q <= dec_instr_d;
      dec_pc_q    <= dec_pc_d;
      rob_tail_q  <= rob_tail_d;
      rat_valid_q <= rat_valid_d;
      for (int i = 0; i < 32; i++) rat_tag_q[i] <= rat_tag_d[i];
    end
  end

endmodule

// File: tb/tb_rtype_issue_unit.sv
// Testbench for rtype_issue_unit: directed scenarios plus randomized traffic
// checked against an architectural model of decode, RAT, ROB tail and D register.
module tb_rtype_issue_unit;
  localparam int XLEN      = 32;
  localparam int NUM_RS    = 2;
  localparam int ROB_DEPTH = 8;
  localparam int TAG_W     = $clog2(ROB_DEPTH);
  localparam int IDX_W     = 1;

  logic clock, reset_n;
  logic in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [NUM_RS-1:0] rs_busy;
  logic rob_full;
  logic [TAG_W-1:0] rob_head;
  logic [4:0] rf_raddr1, rf_raddr2;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;
  logic [TAG_W-1:0] rob_q1_tag, rob_q2_tag;
  logic rob_q1_done, rob_q2_done;
  logic [XLEN-1:0] rob_q1_value, rob_q2_value;
  logic cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0] cdb_value;
  logic commit_valid;
  logic [4:0] commit_rd;
  logic [TAG_W-1:0] commit_tag;
  logic flush;
  logic rs_we;
  logic [IDX_W-1:0] rs_idx;
  logic [5:0] rs_funct;
  logic [TAG_W-1:0] rs_dest_tag;
  logic rs_src1_ready, rs_src2_ready;
  logic [TAG_W-1:0] rs_src1_tag, rs_src2_tag;
  logic [XLEN-1:0] rs_src1_value, rs_src2_value;
  logic rob_alloc;
  logic [TAG_W-1:0] rob_alloc_tag;
  logic [4:0] rob_alloc_rd;
  logic [31:0] rob_alloc_pc;
  logic illegal_instr;

  int checks = 0;
  int errors = 0;

  // Environment: register file and ROB lookup contents.
  logic [XLEN-1:0] rf_mem [32];
  logic            rob_done_m [ROB_DEPTH];
  logic [XLEN-1:0] rob_val_m [ROB_DEPTH];

  assign rf_rdata1    = rf_mem[rf_raddr1];
  assign rf_rdata2    = rf_mem[rf_raddr2];
  assign rob_q1_done  = rob_done_m[rob_q1_tag];
  assign rob_q1_value = rob_val_m[rob_q1_tag];
  assign rob_q2_done  = rob_done_m[rob_q2_tag];
  assign rob_q2_value = rob_val_m[rob_q2_tag];

  // Reference model state.
  bit               m_ratv [32];
  logic [TAG_W-1:0] m_ratt [32];
  int               m_tail;
  bit               m_dv;
  logic [31:0]      m_di, m_dp;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [5:0]       funct;
    logic [TAG_W-1:0] dtag;
    logic [TAG_W-1:0] atag;
    logic             s1r;
    logic [XLEN-1:0]  s1v;
    logic             s2r;
    logic [XLEN-1:0]  s2v;
    logic [4:0]       rd;
    logic [31:0]      pc;
  } pay_t;

  typedef struct {
    logic fire, ready, illegal;
    pay_t pay;
    logic [TAG_W-1:0] s1t, s2t;
  } exp_t;

  pay_t act_pay;
  assign act_pay = {rs_idx, rs_funct, rs_dest_tag, rob_alloc_tag, rs_src1_ready, rs_src1_value,
                    rs_src2_ready, rs_src2_value, rob_alloc_rd, rob_alloc_pc};

  rtype_issue_unit #(.XLEN(XLEN), .NUM_RS(NUM_RS), .ROB_DEPTH(ROB_DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rs_busy(rs_busy), .rob_full(rob_full), .rob_head(rob_head),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rob_q1_tag(rob_q1_tag), .rob_q2_tag(rob_q2_tag),
    .rob_q1_done(rob_q1_done), .rob_q1_value(rob_q1_value),
    .rob_q2_done(rob_q2_done), .rob_q2_value(rob_q2_value),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .flush(flush),
    .rs_we(rs_we), .rs_idx(rs_idx), .rs_funct(rs_funct), .rs_dest_tag(rs_dest_tag),
    .rs_src1_ready(rs_src1_ready), .rs_src1_tag(rs_src1_tag), .rs_src1_value(rs_src1_value),
    .rs_src2_ready(rs_src2_ready), .rs_src2_tag(rs_src2_tag), .rs_src2_value(rs_src2_value),
    .rob_alloc(rob_alloc), .rob_alloc_tag(rob_alloc_tag), .rob_alloc_rd(rob_alloc_rd),
    .rob_alloc_pc(rob_alloc_pc), .illegal_instr(illegal_instr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] fn3,
                                        input logic [4:0] d);
    return {f7, s2, s1, fn3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] s1,
                                        input logic [2:0] fn3, input logic [4:0] d);
    return {im, s1, fn3, d, 7'b0010011};
  endfunction

  function automatic void resolve_m(input logic [4:0] rs, output logic r,
                                    output logic [TAG_W-1:0] t, output logic [XLEN-1:0] v);
    r = 1'b1; t = '0; v = '0;
    if (rs == 0) v = '0;
    else if (m_ratv[rs]) v = rf_mem[rs];
    else begin
      t = m_ratt[rs];
      if (cdb_valid && cdb_tag == t) v = cdb_value;
      else if (rob_done_m[t]) v = rob_val_m[t];
      else r = 1'b0;
    end
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic [6:0] opc;
    logic [2:0] fn3;
    logic b30, op, opi, legal;
    logic [11:0] im;
    int k;
    opc = m_di[6:0]; fn3 = m_di[14:12]; b30 = m_di[30]; im = m_di[31:20];
    op  = (opc == 7'h33);
    opi = (opc == 7'h13);
    legal = opi || (op && (b30 == 1'b0 || fn3 == 3'd0 || fn3 == 3'd5));
    e.fire    = m_dv && legal && !rob_full && (rs_busy != {NUM_RS{1'b1}}) && !flush;
    e.ready   = !flush && (!m_dv || e.fire);
    e.illegal = m_dv && !legal && !flush;
    k = 0;
    while (k < NUM_RS - 1 && rs_busy[k]) k++;
    e.pay.idx = IDX_W'(k);
    case (fn3)
      3'd0: e.pay.funct = (op && b30) ? 6'b011100 : 6'b011011;
      3'd1: e.pay.funct = 6'b011101;
      3'd2: e.pay.funct = 6'b011110;
      3'd3: e.pay.funct = 6'b011111;
      3'd4: e.pay.funct = 6'b100000;
      3'd5: e.pay.funct = b30 ? 6'b100010 : 6'b100001;
      3'd6: e.pay.funct = 6'b100011;
      default: e.pay.funct = 6'b100100;
    endcase
    e.pay.dtag = TAG_W'(m_tail);
    e.pay.atag = TAG_W'(m_tail);
    resolve_m(m_di[19:15], e.pay.s1r, e.s1t, e.pay.s1v);
    resolve_m(m_di[24:20], e.pay.s2r, e.s2t, e.pay.s2v);
    if (opi) begin
      e.pay.s2r = 1'b1;
      e.s2t = '0;
      if (fn3 == 3'd1 || fn3 == 3'd5) e.pay.s2v = XLEN'(im[4:0]);
      else e.pay.s2v = XLEN'(signed'(im));
    end
    e.pay.rd = m_di[11:7];
    e.pay.pc = m_dp;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_ratv[i] = 1'b1; m_ratt[i] = '0; end
    m_tail = 0; m_dv = 1'b0; m_di = '0; m_dp = '0;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_instr = '0; in_pc = '0; rs_busy = '0; rob_full = 0; rob_head = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_value = '0;
    commit_valid = 0; commit_rd = '0; commit_tag = '0; flush = 0;
  endtask

  // Advances one clock and applies the architectural effect of that edge to the model.
  task automatic tick();
    exp_t e;
    logic acc;
    e = predict();
    acc = in_valid && e.ready;
    @(posedge clock);
    if (flush) begin
      m_dv = 1'b0;
      for (int i = 0; i < 32; i++) m_ratv[i] = 1'b1;
      m_tail = int'(rob_head);
    end else begin
      if (commit_valid && !m_ratv[commit_rd] && m_ratt[commit_rd] == commit_tag)
        m_ratv[commit_rd] = 1'b1;
      if (e.fire) begin
        if (m_di[11:7] != 0) begin
          m_ratv[m_di[11:7]] = 1'b0;
          m_ratt[m_di[11:7]] = TAG_W'(m_tail);
        end
        m_tail = (m_tail + 1) % ROB_DEPTH;
      end
      if (acc) begin m_dv = 1'b1; m_di = in_instr; m_dp = in_pc; end
      else if (e.fire || e.illegal) m_dv = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    // Park an instruction in D behind a full RS, then reset in the middle of the stall.
    in_valid = 1; in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3); in_pc = 32'h40;
    tick();
    in_valid = 0; rs_busy = 2'b11;
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    checks++;
    if ({rs_we, rob_alloc, illegal_instr} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got=%b want=000", {rs_we, rob_alloc, illegal_instr});
    end
    checks++;
    if ({rob_alloc_tag, rs_src1_ready, rs_src1_value, rf_raddr1, rob_q1_tag, rob_alloc_pc} !== '0) begin
      errors++; $display("FAIL reset_outputs_zero got tag=%0d pc=%h raddr1=%0d", rob_alloc_tag, rob_alloc_pc, rf_raddr1);
    end
    idle_inputs();
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (rs_we !== 1'b0 || rob_alloc !== 1'b0) begin
        errors++; $display("FAIL reset_discards_d cycle=%0d rs_we=%0b rob_alloc=%0b want=0", c, rs_we, rob_alloc);
      end
      tick();
    end
  endtask

  task automatic test_add_basic();
    do_reset();
    in_valid = 1; in_instr = 32'h002081B3; in_pc = 32'h100;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL add_accept in_ready=%0b want=1", in_ready); end
    tick();
    in_valid = 0;
    #1;
    checks++;
    if (rs_we !== 1'b1 || rob_alloc !== 1'b1 || rs_idx !== 1'b0 || rs_funct !== 6'b011011) begin
      errors++; $display("FAIL add_issue we=%0b alloc=%0b idx=%0d funct=%b want 1 1 0 011011", rs_we, rob_alloc, rs_idx, rs_funct);
    end
    checks++;
    if ({rs_src1_ready, rs_src1_value, rs_src2_ready, rs_src2_value} !== {1'b1, 32'd5, 1'b1, 32'd7}) begin
      errors++; $display("FAIL add_operands got %0b/%0d %0b/%0d want 1/5 1/7", rs_src1_ready, rs_src1_value, rs_src2_ready, rs_src2_value);
    end
    checks++;
    if (rob_alloc_tag !== 3'd0 || rob_alloc_rd !== 5'd3 || rob_alloc_pc !== 32'h100) begin
      errors++; $display("FAIL add_alloc tag=%0d rd=%0d pc=%h want 0 3 100", rob_alloc_tag, rob_alloc_rd, rob_alloc_pc);
    end
    tick();
    #1;
    checks++;
    if (rs_we !== 1'b0) begin errors++; $display("FAIL add_single_cycle rs_we=%0b want=0", rs_we); end
  endtask

  task automatic test_back_to_back();
    for (int v = 0; v < 2; v++) begin
      do_reset();
      in_valid = 1; in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3); in_pc = 32'h0;
      tick();
      in_instr = enc_r(7'h20, 5'd1, 5'd3, 3'd0, 5'd4); in_pc = 32'h4;
      #1;
      checks++;
      if (rs_we !== 1'b1 || rob_alloc_tag !== 3'd0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_first v=%0d we=%0b tag=%0d ready=%0b want 1 0 1", v, rs_we, rob_alloc_tag, in_ready);
      end
      tick();
      in_valid = 0;
      if (v == 1) begin cdb_valid = 1; cdb_tag = 3'd0; cdb_value = 32'd12; end
      #1;
      checks++;
      if (rs_we !== 1'b1 || rs_funct !== 6'b011100 || rob_alloc_tag !== 3'd1 || rs_dest_tag !== 3'd1) begin
        errors++; $display("FAIL b2b_sub v=%0d we=%0b funct=%b tag=%0d want 1 011100 1", v, rs_we, rs_funct, rob_alloc_tag);
      end
      checks++;
      if (v == 0 && (rs_src1_ready !== 1'b0 || rs_src1_tag !== 3'd0 || rs_src1_value !== 32'd0)) begin
        errors++; $display("FAIL b2b_src1_wait ready=%0b tag=%0d val=%0d want 0 0 0", rs_src1_ready, rs_src1_tag, rs_src1_value);
      end else if (v == 1 && (rs_src1_ready !== 1'b1 || rs_src1_value !== 32'd12)) begin
        errors++; $display("FAIL b2b_src1_cdb ready=%0b val=%0d want 1 12", rs_src1_ready, rs_src1_value);
      end
      checks++;
      if (rs_src2_ready !== 1'b1 || rs_src2_value !== 32'd5) begin
        errors++; $display("FAIL b2b_src2 ready=%0b val=%0d want 1 5", rs_src2_ready, rs_src2_value);
      end
      tick();
      cdb_valid = 0;
    end
  endtask

  task automatic test_rs_stall();
    do_reset();
    in_valid = 1; in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd5); in_pc = 32'h20;
    tick();
    in_valid = 0; rs_busy = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || rs_we !== 1'b0 || rob_alloc !== 1'b0) begin
        errors++; $display("FAIL stall cycle=%0d ready=%0b we=%0b alloc=%0b want 0 0 0", c, in_ready, rs_we, rob_alloc);
      end
      tick();
    end
    rs_busy = 2'b10;
    #1;
    checks++;
    if (rs_we !== 1'b1 || rs_idx !== 1'b0 || rob_alloc_tag !== 3'd0) begin
      errors++; $display("FAIL stall_release we=%0b idx=%0d tag=%0d want 1 0 0", rs_we, rs_idx, rob_alloc_tag);
    end
    tick();
    rs_busy = 2'b01;
    in_valid = 1; in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd6);
    tick();
    in_valid = 0;
    #1;
    checks++;
    if (rs_we !== 1'b1 || rs_idx !== 1'b1 || rs_funct !== 6'b100100) begin
      errors++; $display("FAIL rs_slot1 we=%0b idx=%0d funct=%b want 1 1 100100", rs_we, rs_idx, rs_funct);
    end
    tick();
    rs_busy = 2'b00;
  endtask

  task automatic test_wrap_x0_illegal();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k < 9) begin
        in_valid = 1; in_instr = enc_i(12'(k), 5'd0, 3'd0, 5'((k % 7) + 1)); in_pc = 32'(k * 4);
      end else in_valid = 0;
      #1;
      if (k > 0) begin
        checks++;
        if (rs_we !== 1'b1 || rob_alloc_tag !== 3'((k - 1) % 8)) begin
          errors++; $display("FAIL wrap_tag k=%0d we=%0b tag=%0d want 1 %0d", k, rs_we, rob_alloc_tag, (k - 1) % 8);
        end
      end
      tick();
    end
    in_valid = 1; in_instr = enc_i(12'd5, 5'd0, 3'd0, 5'd0); in_pc = 32'h80;
    tick();
    in_valid = 0;
    #1;
    checks++;
    if (rs_we !== 1'b1 || rs_src2_value !== 32'd5 || rs_src2_ready !== 1'b1 || rob_alloc_rd !== 5'd0 || rob_alloc_tag !== 3'd1) begin
      errors++; $display("FAIL addi_x0 we=%0b src2=%0d rd=%0d tag=%0d want 1 5 0 1", rs_we, rs_src2_value, rob_alloc_rd, rob_alloc_tag);
    end
    tick();
    in_valid = 1; in_instr = 32'h00000003; in_pc = 32'h84;
    tick();
    in_valid = 0;
    #1;
    checks++;
    if (illegal_instr !== 1'b1 || rs_we !== 1'b0 || rob_alloc !== 1'b0) begin
      errors++; $display("FAIL illegal_pulse ill=%0b we=%0b alloc=%0b want 1 0 0", illegal_instr, rs_we, rob_alloc);
    end
    tick();
    in_valid = 1; in_instr = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd5); in_pc = 32'h88;
    #1;
    checks++;
    if (illegal_instr !== 1'b0) begin errors++; $display("FAIL illegal_one_cycle ill=%0b want 0", illegal_instr); end
    tick();
    in_valid = 0;
    #1;
    checks++;
    if (rs_we !== 1'b1 || rob_alloc_tag !== 3'd2 || rs_src1_ready !== 1'b1 || rs_src1_value !== 32'd0) begin
      errors++; $display("FAIL after_illegal we=%0b tag=%0d s1=%0b/%0d want 1 2 1/0", rs_we, rob_alloc_tag, rs_src1_ready, rs_src1_value);
    end
    tick();
  endtask

  task automatic test_commit_flush();
    do_reset();
    in_valid = 1; in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3); in_pc = 32'h0;
    tick();
    in_pc = 32'h4;
    tick();
    in_valid = 0;
    tick();
    commit_valid = 1; commit_rd = 5'd3; commit_tag = 3'd0;
    in_valid = 1; in_instr = enc_r(7'h20, 5'd1, 5'd3, 3'd0, 5'd4); in_pc = 32'h8;
    tick();
    commit_valid = 0; in_valid = 0;
    #1;
    checks++;
    if (rs_we !== 1'b1 || rs_src1_ready !== 1'b0 || rs_src1_tag !== 3'd1) begin
      errors++; $display("FAIL stale_commit we=%0b s1_ready=%0b s1_tag=%0d want 1 0 1", rs_we, rs_src1_ready, rs_src1_tag);
    end
    tick();
    flush = 1; rob_head = 3'd5; in_valid = 1; in_instr = enc_r(7'h00, 5'd1, 5'd3, 3'd0, 5'd6);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks_accept in_ready=%0b want 0", in_ready); end
    tick();
    flush = 0;
    tick();
    in_valid = 0;
    #1;
    checks++;
    if (rs_we !== 1'b1 || rob_alloc_tag !== 3'd5 || rs_src1_ready !== 1'b1 || rs_src1_value !== 32'd11) begin
      errors++; $display("FAIL flush_recover we=%0b tag=%0d s1=%0b/%0d want 1 5 1/11", rs_we, rob_alloc_tag, rs_src1_ready, rs_src1_value);
    end
    tick();
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    logic [4:0] d, s1, s2;
    logic [2:0] fn3;
    k = $urandom_range(0, 9);
    d = 5'($urandom_range(0, 7)); s1 = 5'($urandom_range(0, 7)); s2 = 5'($urandom_range(0, 7));
    fn3 = 3'($urandom);
    if (k < 5) return enc_r(($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00, s2, s1, fn3, d);
    else if (k < 9) return enc_i(12'($urandom), s1, fn3, d);
    else return {25'($urandom), 7'($urandom)};
  endfunction

  task automatic test_random();
    exp_t e;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 0)
        for (int t = 0; t < ROB_DEPTH; t++) begin
          rob_done_m[t] = ($urandom_range(0, 2) == 0);
          rob_val_m[t] = $urandom;
        end
      in_valid = ($urandom_range(0, 3) != 0);
      in_instr = rand_instr();
      in_pc = $urandom;
      rs_busy = NUM_RS'($urandom);
      rob_full = ($urandom_range(0, 7) == 0);
      cdb_valid = 1'($urandom); cdb_tag = TAG_W'($urandom); cdb_value = $urandom;
      commit_valid = 1'($urandom);
      commit_rd = 5'($urandom_range(0, 7));
      commit_tag = $urandom_range(0, 1) ? m_ratt[commit_rd] : TAG_W'($urandom);
      flush = ($urandom_range(0, 29) == 0);
      rob_head = TAG_W'($urandom);
      #1;
      e = predict();
      checks++;
      if ({in_ready, rs_we, rob_alloc, illegal_instr} !== {e.ready, e.fire, e.fire, e.illegal}) begin
        errors++;
        $display("FAIL rand_ctrl cycle=%0d got ready/we/alloc/ill=%b want %b", c,
                 {in_ready, rs_we, rob_alloc, illegal_instr}, {e.ready, e.fire, e.fire, e.illegal});
      end
      if (e.fire) begin
        checks++;
        if (act_pay !== e.pay) begin
          errors++; $display("FAIL rand_payload cycle=%0d got=%h want=%h", c, act_pay, e.pay);
        end
        if (!e.pay.s1r || !e.pay.s2r) begin
          checks++;
          if ((!e.pay.s1r && rs_src1_tag !== e.s1t) || (!e.pay.s2r && rs_src2_tag !== e.s2t)) begin
            errors++; $display("FAIL rand_wait_tag cycle=%0d got=%0d/%0d want=%0d/%0d", c, rs_src1_tag, rs_src2_tag, e.s1t, e.s2t);
          end
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    rf_mem[0] = '0; rf_mem[1] = 32'd5; rf_mem[2] = 32'd7; rf_mem[3] = 32'd11;
    for (int t = 0; t < ROB_DEPTH; t++) begin rob_done_m[t] = 1'b0; rob_val_m[t] = '0; end
    test_reset();
    test_add_basic();
    test_back_to_back();
    test_rs_stall();
    test_wrap_x0_illegal();
    test_commit_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtype_issue_unit.md
# rtype_issue_unit

Parametrised Tomasulo issue unit for the RV32I core: accepts one instruction per cycle over a valid/ready handshake, decodes OP (0110011) and OP-IMM (0010011) ALU instructions, renames through an internal RAT, allocates a ROB tail tag and writes one ALU reservation-station entry. It sits between fetch and the ALU RS/ROB. Against the previous issue logic it adds:
- configurable RS/ROB depth;
- reset, back-pressure and x0 handling;
- CDB/ROB operand forwarding;
- commit-side RAT release and flush recovery.

## Interface
- XLEN, 32, datapath width
- NUM_RS, 2, ALU reservation-station entries
- ROB_DEPTH, 8, ROB entries; power of two; TAG_W = clog2(ROB_DEPTH)
- clock  in  1  rising-edge clock
- reset_n  in  1  reset, asynchronous, active-low
- in_valid / in_ready  in / out  1 / 1  instruction handshake
- in_instr / in_pc  in  32 / 32  instruction word and its PC
- rs_busy  in  NUM_RS  busy bits from the RS
- rob_full  in  1  ROB has no free entry
- rob_head  in  TAG_W  ROB head, loaded into the tail on flush
- rf_raddr1, rf_raddr2  out  5  register-file read addresses (combinational from decode register)
- rf_rdata1, rf_rdata2  in  XLEN  register-file read data (same cycle)
- rob_q1_tag, rob_q2_tag  out  TAG_W  ROB lookup tags
- rob_q1_done / rob_q1_value, rob_q2_done / rob_q2_value  in  1 / XLEN  lookup result (same cycle)
- cdb_valid / cdb_tag / cdb_value  in  1 / TAG_W / XLEN  result broadcast
- commit_valid / commit_rd / commit_tag  in  1 / 5 / TAG_W  ROB retirement
- flush  in  1  synchronous pipeline flush
- rs_we / rs_idx / rs_funct / rs_dest_tag  out  1 / clog2(NUM_RS) / 6 / TAG_W  RS write port
- rs_src{1,2}_ready / rs_src{1,2}_tag / rs_src{1,2}_value  out  1 / TAG_W / XLEN  operands
- rob_alloc / rob_alloc_tag / rob_alloc_rd / rob_alloc_pc  out  1 / TAG_W / 5 / 32  ROB allocation
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode

## Operation
- **Stage D.** Decode register `dec_valid/instr/pc` is loaded when `in_valid && in_ready`; `in_ready = !dec_valid || issue_fire`.
- **Stage I (combinational from D).** `issue_fire = dec_valid && legal && !rob_full && |(~rs_busy) && !flush`.
- **RS slot.** `rs_idx` is the lowest index with `rs_busy == 0`.
- **funct codes.**
  - OP, bit30 = 0, f3 000..111: ADD 011011, SLL 011101, SLT 011110, SLTU 011111, XOR 100000, SRL 100001, OR 100011, AND 100100.
  - OP, bit30 = 1: f3 000 SUB 011100; f3 101 SRA 100010.
  - OP-IMM uses the same codes with bit30 ignored except for SRAI.
- **Legality.**
  - OP-IMM src2 = sign-extended `imm[11:0]`, ready = 1, tag = 0.
  - Shifts take shamt in `imm[4:0]`.
  - Illegal: any other opcode, or OP with bit30 = 1 and f3 not in {000, 101}. An illegal instruction is dropped from D in one cycle, `illegal_instr = 1`, and nothing is allocated.
- **Operand resolution, per source in priority order:**
  1. rs == x0 → ready, value 0.
  2. RAT valid → ready, `rf_rdata`.
  3. `cdb_valid && cdb_tag == RAT tag` → ready, `cdb_value`.
  4. `rob_q_done` → ready, `rob_q_value`.
  5. Otherwise not ready, tag = RAT tag, value 0.
- **On issue_fire:**
  - `rob_alloc_tag = rob_tail`, and `rob_tail` increments, wrapping modulo ROB_DEPTH.
  - If rd ≠ 0: `RAT[rd] <= {valid = 0, tag = rob_tail}`. rd = x0 never renames.
- **Commit.** When `commit_valid` and `RAT[commit_rd]` is invalid with tag == `commit_tag`, set it valid. A same-cycle issue to the same rd wins.
- **Flush.** Flush has priority over everything except reset. It:
  - clears `dec_valid`;
  - sets every RAT entry valid;
  - sets `rob_tail <= rob_head`;
  - suppresses `issue_fire` and accept.

## Timing
- Reset (async assert, sync release):
  - `dec_valid = 0`, `rob_tail = 0`, all RAT entries valid with tag 0.
  - All outputs 0, except `in_ready = 1`.
- **Latency.** Accepted at edge N, issued in cycle N+1 (`rs_we`/`rob_alloc` high for exactly one cycle); RS and ROB capture at the end of N+1.
- **Throughput.** One issue per cycle with no stall; a back-to-back dependent instruction sees the previous rename, because the RAT is written at the same edge that loads D.
- **Stalls.** `rob_full` or `rs_busy` all ones holds D, `in_ready = 0`, and all write outputs are 0.
- **Reset mid-stall** discards D with no allocation.

## Test plan
- Reset, then `add x3,x1,x2` (0x002081B3) with RAT all valid, rf = 5 / 7 → cycle N+1:
  - `rs_we = 1`, `rs_idx = 0`, funct 011011, both srcs ready with values 5 / 7, `rob_alloc_tag = 0`;
  - `RAT[3]` = tag 0, invalid.
- `add x3,x1,x2` then `sub x4,x3,x1` back to back → two consecutive issue cycles; the second has src1 not ready with tag 0, funct 011100, tag 1.
- As above with `cdb_valid = 1`, `cdb_tag = 0`, `cdb_value = 12` in the sub's issue cycle → src1 ready, value 12.
- `rs_busy = 2'b11` for 3 cycles → `in_ready = 0` and `rs_we = 0` for 3 cycles; the instruction issues on the cycle `rs_busy` becomes 2'b10, with `rs_idx = 0`.
- Issue 9 instructions with ROB_DEPTH = 8 and `rob_full` never set → tags 0..7 then 0 (wrap). Then `addi x0,x0,5` → issues with `rs_src2_value = 5` and no RAT change. Then opcode 0x03 → `illegal_instr` pulse, no allocation.
- Commit tag 0 for x3 after x3 was re-renamed to tag 1 → `RAT[3]` stays invalid. Then `flush` with `rob_head = 5` → all RAT valid, the next `rob_alloc_tag = 5`.
